// File: rtl/popcount_seq.sv
// popcount_seq: sequential population counter, CHUNK bits per clock.
// Optional threshold compare (thresh/out_ge) enabled by POPCNT_THRESH_EN.
module popcount_seq #(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
`ifdef POPCNT_THRESH_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             out_ge,
`endif
  output logic             out_parity
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int SW     = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t state, state_d;

  logic [SW-1:0]    shift;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] sum;
  logic [IDX_W-1:0] idx;
  logic             last;

  function automatic logic [CNT_W-1:0] pc(
    input logic [CHUNK-1:0] v
  );
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++)
      s = s + CNT_W'(v[i]);
    return s;
  endfunction

  assign sum  = acc + pc(shift[CHUNK-1:0]);
  assign last = (idx == IDX_W'(NCHUNK - 1));

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_parity = out_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid)  state_d = COUNT;
      COUNT:   if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

`ifdef POPCNT_THRESH_EN
  logic [CNT_W-1:0] thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr    <= '0;
      out_ge <= 1'b0;
    end else begin
      if (state == IDLE && in_valid)
        thr <= thresh;
      if (state == COUNT && last)
        out_ge <= (sum >= thr);
    end
  end
`endif

  // Zero-padded shift reg: pad bits add nothing to the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shift <= SW'(in_data);
          acc   <= '0;
          idx   <= '0;
        end
        COUNT: begin
          acc   <= sum;
          shift <= shift >> CHUNK;
          idx   <= idx + IDX_W'(1);
          if (last)
            out_count <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: directed + random checks of popcount_seq.
// Aux instances cover CHUNK=4 (padded) and CHUNK=9.
module tb_popcount_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_count;
  logic       out_parity;
  logic [3:0] thresh = '0;
  logic       out_ge;

  logic       ax_valid = 1'b0;
  logic       ax_ready = 1'b0;
  logic [8:0] ax_data = '0;
  logic [3:0] ax_thr = '0;
  logic       ir1, ov1, op1, ge1;
  logic       ir2, ov2, op2, ge2;
  logic [3:0] oc1, oc2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  popcount_seq #(.WIDTH(9), .CHUNK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count),
`ifdef POPCNT_THRESH_EN
    .thresh(thresh), .out_ge(out_ge),
`endif
    .out_parity(out_parity)
  );

  popcount_seq #(.WIDTH(9), .CHUNK(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ax_valid), .in_ready(ir1),
    .in_data(ax_data),
    .out_valid(ov1), .out_ready(ax_ready),
    .out_count(oc1),
`ifdef POPCNT_THRESH_EN
    .thresh(ax_thr), .out_ge(ge1),
`endif
    .out_parity(op1)
  );

  popcount_seq #(.WIDTH(9), .CHUNK(9)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ax_valid), .in_ready(ir2),
    .in_data(ax_data),
    .out_valid(ov2), .out_ready(ax_ready),
    .out_count(oc2),
`ifdef POPCNT_THRESH_EN
    .thresh(ax_thr), .out_ge(ge2),
`endif
    .out_parity(op2)
  );

`ifndef POPCNT_THRESH_EN
  assign out_ge = 1'b0;
  assign ge1 = 1'b0;
  assign ge2 = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] d,
                      input int ec,
                      input logic [3:0] thr,
                      input logic ege,
                      input int hold);
    int lat;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    thresh   = thr;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    thresh   = ~thr;
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, 3);
    chk("count", out_count, ec);
    chk("parity", out_parity, ec & 1);
`ifdef POPCNT_THRESH_EN
    chk("ge", out_ge, ege);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 9'h1FF;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_count", out_count, ec);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_valid", out_valid, 0);
    chk("pop_ready", in_ready, 1);
  endtask

  initial begin
    logic [8:0] rd;
    logic [3:0] rt;
    int ec, l1, l2;

    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_parity", out_parity, 0);
`ifdef POPCNT_THRESH_EN
    chk("rst_ge", out_ge, 0);
`endif
    rst_n = 1'b1;
    tick();

    send(9'h1FF, 9, 4'd0, 1'b1, 0);
    send(9'h000, 0, 4'd0, 1'b1, 0);
    send(9'b101010101, 5, 4'd9, 1'b0, 0);
    send(9'h0F0, 4, 4'd4, 1'b1, 5);

    in_valid = 1'b1;
    in_data  = 9'h1FF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_count", out_count, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_novalid", out_valid, 0);
    end
    send(9'h00F, 4, 4'd3, 1'b1, 0);

    send(9'b000011111, 5, 4'd5, 1'b1, 0);
    send(9'b000001111, 4, 4'd5, 1'b0, 0);

    ax_valid = 1'b1;
    ax_data  = 9'h1FF;
    ax_thr   = 4'd9;
    tick();
    ax_valid = 1'b0;
    ax_data  = '0;
    l1 = -1;
    l2 = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ov1 && l1 < 0) l1 = c;
      if (ov2 && l2 < 0) l2 = c;
    end
    chk("c4_latency", l1, 3);
    chk("c4_count", oc1, 9);
    chk("c4_parity", op1, 1);
    chk("c9_latency", l2, 1);
    chk("c9_count", oc2, 9);
`ifdef POPCNT_THRESH_EN
    chk("c4_ge", ge1, 1);
    chk("c9_ge", ge2, 1);
`endif
    ax_ready = 1'b1;
    tick();
    ax_ready = 1'b0;
    chk("c4_pop", ir1, 1);
    chk("c9_pop", ir2, 1);

    for (int k = 0; k < 200; k++) begin
      rd = 9'($urandom);
      rt = 4'($urandom_range(0, 9));
      ec = $countones(rd);
      send(rd, ec, rt, (ec >= int'(rt)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
